thick_line_engine: RTL and testbench

- Parametrised thick-line rasteriser. It draws a Bresenham line from (X0,Y0) to (X1,Y1) and expands it to Thickness pixels along the minor axis.
- It emits one pixel write at a time to the AMC over the Draw/Write_Finish handshake, computing Pixel_Address internally.
- It sits between the ASC register file and the AMC.
- It replaces the nested line-of-lines scheme with a single FSM that fills every pixel of sloped thick lines.

---
 rtl/thick_line_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_thick_line_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/thick_line_engine.sv
// Thick Bresenham line rasteriser: walks the major axis, fans each step out across the minor axis, and hands pixels to the AMC one at a time.
// Optional macro CLIP_EN: when defined, off-screen pixels are skipped; otherwise coordinates wrap within the buffer.
module thick_line_engine #(
  parameter int          XW        = 9,
  parameter int          YW        = 8,
  parameter int          TW        = 4,
  parameter logic [31:0] BASE_ADDR = 32'h08000000,
  parameter int          ROW_SHIFT = 10,
  parameter int          X_LIMIT   = 320,
  parameter int          Y_LIMIT   = 240
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          Go,
  input  logic [XW-1:0] X0,
  input  logic [XW-1:0] X1,
  input  logic [YW-1:0] Y0,
  input  logic [YW-1:0] Y1,
  input  logic [TW-1:0] Thickness,
  input  logic [15:0]   Color_In,
  output logic          Done,
  output logic          Draw,
  input  logic          Write_Finish,
  output logic [31:0]   Pixel_Address,
  output logic [15:0]   Pixel_Color
);

  localparam int CW = ((XW > YW) ? XW : YW) + 2;

  typedef enum logic [2:0] {IDLE, SETUP, EMIT, ADV, DONE} state_t;

  state_t state, state_n;

  logic [XW-1:0]        x0_r, x1_r, x0_n, x1_n;
  logic [YW-1:0]        y0_r, y1_r, y0_n, y1_n;
  logic [TW-1:0]        t_r, t_n;
  logic [15:0]          color_r, color_n;
  logic                 steep_r, steep_n;
  logic                 step_neg_r, step_neg_n;
  logic signed [CW-1:0] maj_r, maj_n, min_r, min_n, end_r, end_n;
  logic signed [CW-1:0] dmaj_r, dmaj_n, dmin_r, dmin_n, err_r, err_n, k_r, k_n;
  logic                 draw_r, draw_n;
  logic [31:0]          addr_r, addr_n;

  // Line setup values, derived from the latched endpoints.
  logic signed [CW-1:0] ex0, ey0, ex1, ey1, dx, dy, adx, ady;
  logic signed [CW-1:0] a0, b0, a1, b1;
  logic signed [CW-1:0] maj0_c, min0_c, maj1_c, min1_c, dmaj_c, dmin_d, dmin_c, err_c;
  logic                 steep_c, step_neg_c;

  always_comb begin
    ex0 = CW'(x0_r);
    ey0 = CW'(y0_r);
    ex1 = CW'(x1_r);
    ey1 = CW'(y1_r);
    dx  = ex1 - ex0;
    dy  = ey1 - ey0;
    adx = dx[CW-1] ? -dx : dx;
    ady = dy[CW-1] ? -dy : dy;
    steep_c = (ady > adx);
    a0 = steep_c ? ey0 : ex0;
    b0 = steep_c ? ex0 : ey0;
    a1 = steep_c ? ey1 : ex1;
    b1 = steep_c ? ex1 : ey1;
    if (a0 > a1) begin
      maj0_c = a1;
      min0_c = b1;
      maj1_c = a0;
      min1_c = b0;
    end else begin
      maj0_c = a0;
      min0_c = b0;
      maj1_c = a1;
      min1_c = b1;
    end
    dmaj_c     = maj1_c - maj0_c;
    dmin_d     = min1_c - min0_c;
    dmin_c     = dmin_d[CW-1] ? -dmin_d : dmin_d;
    step_neg_c = (min0_c > min1_c);
    err_c      = -(dmaj_c >>> 1);
  end

  // The thickness span runs from k_first to k_last inclusive, exactly T offsets.
  logic signed [CW-1:0] t_ext, k_first, k_last;
  assign t_ext   = CW'(t_r);
  assign k_first = -((t_ext - CW'(1)) >>> 1);
  assign k_last  = t_ext >>> 1;

  logic signed [CW-1:0] pix_min, px, py;
  logic                 in_range;
  logic [31:0]          pix_addr;

  assign pix_min = min_r + k_r;
  assign px      = steep_r ? pix_min : maj_r;
  assign py      = steep_r ? maj_r : pix_min;

`ifdef CLIP_EN
  localparam logic signed [CW-1:0] XLIM = CW'(X_LIMIT);
  localparam logic signed [CW-1:0] YLIM = CW'(Y_LIMIT);
  assign in_range = !px[CW-1] && (px < XLIM) && !py[CW-1] && (py < YLIM);
`else
  localparam int unused_limits = X_LIMIT + Y_LIMIT;
  assign in_range = 1'b1;
`endif

  // Truncation makes negative or oversized coordinates wrap inside the buffer.
  logic [CW-XW+CW-YW-1:0] unused_high_bits;
  assign unused_high_bits = {px[CW-1:XW], py[CW-1:YW]};
  assign pix_addr = BASE_ADDR + (32'(py[YW-1:0]) << ROW_SHIFT) + (32'(px[XW-1:0]) << 1);

  // Bresenham error step for the next major position.
  logic signed [CW-1:0] err_acc;
  assign err_acc = err_r + dmin_r;

  always_comb begin
    state_n    = state;
    x0_n       = x0_r;
    x1_n       = x1_r;
    y0_n       = y0_r;
    y1_n       = y1_r;
    t_n        = t_r;
    color_n    = color_r;
    steep_n    = steep_r;
    step_neg_n = step_neg_r;
    maj_n      = maj_r;
    min_n      = min_r;
    end_n      = end_r;
    dmaj_n     = dmaj_r;
    dmin_n     = dmin_r;
    err_n      = err_r;
    k_n        = k_r;
    draw_n     = draw_r;
    addr_n     = addr_r;

    case (state)
      IDLE: begin
        draw_n = 1'b0;
        if (Go) begin
          x0_n    = X0;
          x1_n    = X1;
          y0_n    = Y0;
          y1_n    = Y1;
          t_n     = (Thickness == '0) ? TW'(1) : Thickness;
          color_n = Color_In;
          state_n = SETUP;
        end
      end
      SETUP: begin
        steep_n    = steep_c;
        step_neg_n = step_neg_c;
        maj_n      = maj0_c;
        min_n      = min0_c;
        end_n      = maj1_c;
        dmaj_n     = dmaj_c;
        dmin_n     = dmin_c;
        err_n      = err_c;
        k_n        = k_first;
        state_n    = EMIT;
      end
      EMIT: begin
        if (!draw_r && in_range) begin
          draw_n = 1'b1;
          addr_n = pix_addr;
        end else if (!draw_r || Write_Finish) begin
          draw_n = 1'b0;
          if (k_r == k_last) begin
            state_n = ADV;
          end else begin
            k_n = k_r + CW'(1);
          end
        end
      end
      ADV: begin
        if (maj_r == end_r) begin
          state_n = DONE;
        end else begin
          maj_n = maj_r + CW'(1);
          k_n   = k_first;
          if (err_acc > 0) begin
            min_n = step_neg_r ? (min_r - CW'(1)) : (min_r + CW'(1));
            err_n = err_acc - dmaj_r;
          end else begin
            err_n = err_acc;
          end
          state_n = EMIT;
        end
      end
      DONE: begin
        draw_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        draw_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Falling-edge registers keep the handshake aligned with the AMC.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x0_r       <= '0;
      x1_r       <= '0;
      y0_r       <= '0;
      y1_r       <= '0;
      t_r        <= '0;
      color_r    <= '0;
      steep_r    <= 1'b0;
      step_neg_r <= 1'b0;
      maj_r      <= '0;
      min_r      <= '0;
      end_r      <= '0;
      dmaj_r     <= '0;
      dmin_r     <= '0;
      err_r      <= '0;
      k_r        <= '0;
      draw_r     <= 1'b0;
      addr_r     <= BASE_ADDR;
    end else begin
      state      <= state_n;
      x0_r       <= x0_n;
      x1_r       <= x1_n;
      y0_r       <= y0_n;
      y1_r       <= y1_n;
      t_r        <= t_n;
      color_r    <= color_n;
      steep_r    <= steep_n;
      step_neg_r <= step_neg_n;
      maj_r      <= maj_n;
      min_r      <= min_n;
      end_r      <= end_n;
      dmaj_r     <= dmaj_n;
      dmin_r     <= dmin_n;
      err_r      <= err_n;
      k_r        <= k_n;
      draw_r     <= draw_n;
      addr_r     <= addr_n;
    end
  end

  assign Done          = (state == IDLE);
  assign Draw          = draw_r;
  assign Pixel_Address = addr_r;
  assign Pixel_Color   = color_r;

endmodule

// File: tb/tb_thick_line_engine.sv
// Directed bench for thick_line_engine: an AMC responder records every pixel request and the
// recorded addresses are compared against hand-worked pixel lists (CLIP_EN-aware).
module tb_thick_line_engine;

  localparam logic [31:0] BASE = 32'h08000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Go;
  logic [8:0]  X0, X1;
  logic [7:0]  Y0, Y1;
  logic [3:0]  Thickness;
  logic [15:0] Color_In;
  logic        Done, Draw, Write_Finish;
  logic [31:0] Pixel_Address;
  logic [15:0] Pixel_Color;

  int          total = 0;
  int          bad = 0;
  int          wf_delay = 1;
  bit          stab_check = 1'b0;
  int          unstable_cnt = 0;
  logic [31:0] held_addr;
  logic [31:0] cap_q[$];
  logic [31:0] exp_q[$];

  thick_line_engine dut (
    .clk(clk), .resetn(resetn), .Go(Go),
    .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1),
    .Thickness(Thickness), .Color_In(Color_In),
    .Done(Done), .Draw(Draw), .Write_Finish(Write_Finish),
    .Pixel_Address(Pixel_Address), .Pixel_Color(Pixel_Color)
  );

  always #5 clk = ~clk;

  // AMC model: records each request, holds Write_Finish off for wf_delay cycles.
  initial begin
    Write_Finish = 1'b0;
    forever begin
      @(posedge clk);
      if (Draw) begin
        held_addr = Pixel_Address;
        cap_q.push_back(Pixel_Address);
        for (int i = 1; i < wf_delay; i++) begin
          @(posedge clk);
          if (stab_check && (!Draw || Pixel_Address != held_addr)) unstable_cnt++;
        end
        Write_Finish = 1'b1;
        @(posedge clk);
        Write_Finish = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] x1,
                               input logic [7:0] y1, input logic [3:0] t, input logic [15:0] col);
    cap_q.delete();
    exp_q.delete();
    X0 = x0; Y0 = y0; X1 = x1; Y1 = y1; Thickness = t; Color_In = col;
    @(posedge clk);
    Go = 1'b1;
    @(posedge clk);
    Go = 1'b0;
    X0 = ~x0; Y0 = ~y0; X1 = ~x1; Y1 = ~y1; Thickness = ~t; Color_In = ~col;
  endtask

  function automatic void add_pix(input int px, input int py);
    exp_q.push_back(BASE + (32'(py) << 10) + (32'(px) << 1));
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    checkOutput({tag, "_busy"}, 32'(Done), 32'd0);
    while (!Done && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(Done), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic compare_caps(input string tag);
    checkOutput({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) checkOutput($sformatf("%s_pix%0d", tag, i), cap_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int n;
    resetn = 1'b0; Go = 1'b0;
    X0 = '0; X1 = '0; Y0 = '0; Y1 = '0; Thickness = '0; Color_In = '0;
    repeat (3) @(posedge clk);
    checkOutput("rst_done", 32'(Done), 32'd1);
    checkOutput("rst_draw", 32'(Draw), 32'd0);
    checkOutput("rst_addr", Pixel_Address, BASE);
    checkOutput("rst_color", 32'(Pixel_Color), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Horizontal single-width line.
    applyStimulus(9'd10, 8'd20, 9'd14, 8'd20, 4'd1, 16'hABCD);
    for (int x = 10; x <= 14; x++) add_pix(x, 20);
    wait_idle("horiz");
    compare_caps("horiz");
    checkOutput("horiz_color", 32'(Pixel_Color), 32'h0000ABCD);

    // Steep line: y is the major axis.
    applyStimulus(9'd5, 8'd5, 9'd7, 8'd15, 4'd1, 16'h1234);
    begin
      int sx[11] = '{5, 5, 5, 6, 6, 6, 6, 6, 7, 7, 7};
      for (int i = 0; i < 11; i++) add_pix(sx[i], 5 + i);
    end
    wait_idle("steep");
    compare_caps("steep");

    // Thickness 3 on a shallow slope.
    applyStimulus(9'd10, 8'd20, 9'd12, 8'd21, 4'd3, 16'h0F0F);
    add_pix(10, 19); add_pix(10, 20); add_pix(10, 21);
    add_pix(11, 19); add_pix(11, 20); add_pix(11, 21);
    add_pix(12, 20); add_pix(12, 21); add_pix(12, 22);
    wait_idle("thick3");
    compare_caps("thick3");

    // Thickness span crossing the top edge.
    applyStimulus(9'd0, 8'd0, 9'd2, 8'd0, 4'd3, 16'h5555);
    for (int x = 0; x <= 2; x++) begin
`ifndef CLIP_EN
      add_pix(x, 255);
`endif
      add_pix(x, 0);
      add_pix(x, 1);
    end
    wait_idle("edge");
    compare_caps("edge");

    // Single point, thickness 0 behaves as 1.
    applyStimulus(9'd100, 8'd100, 9'd100, 8'd100, 4'd0, 16'h7777);
    add_pix(100, 100);
    wait_idle("pt_t0");
    compare_caps("pt_t0");

    // Single point, even thickness 4: offsets -1..+2.
    applyStimulus(9'd100, 8'd100, 9'd100, 8'd100, 4'd4, 16'h8888);
    for (int y = 99; y <= 102; y++) add_pix(100, y);
    wait_idle("pt_t4");
    compare_caps("pt_t4");

    // Slow AMC plus a stray Go mid-line.
    wf_delay = 5;
    stab_check = 1'b1;
    unstable_cnt = 0;
    applyStimulus(9'd30, 8'd40, 9'd33, 8'd40, 4'd1, 16'h2468);
    for (int x = 30; x <= 33; x++) add_pix(x, 40);
    n = 0;
    while (cap_q.size() < 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    X0 = 9'd0; Y0 = 8'd0; X1 = 9'd0; Y1 = 8'd0; Thickness = 4'd2;
    Go = 1'b1;
    @(posedge clk);
    Go = 1'b0;
    wait_idle("slow");
    compare_caps("slow");
    checkOutput("slow_stable", 32'(unstable_cnt), 32'd0);
    checkOutput("slow_color", 32'(Pixel_Color), 32'h00002468);
    repeat (10) @(posedge clk);
    checkOutput("slow_no_restart", 32'(cap_q.size()), 32'd4);
    stab_check = 1'b0;

    // Reset during the third pixel of a 10-pixel line.
    wf_delay = 4;
    applyStimulus(9'd0, 8'd50, 9'd9, 8'd50, 4'd1, 16'h9999);
    n = 0;
    while (cap_q.size() < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput("mid_reached3", 32'(cap_q.size()), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("mid_draw_async", 32'(Draw), 32'd0);
    checkOutput("mid_done", 32'(Done), 32'd1);
    repeat (2) @(posedge clk);
    resetn = 1'b1;
    repeat (30) @(posedge clk);
    checkOutput("mid_no_more", 32'(cap_q.size()), 32'd3);
    checkOutput("mid_done_after", 32'(Done), 32'd1);
    checkOutput("mid_addr", Pixel_Address, BASE);
    checkOutput("mid_color", 32'(Pixel_Color), 32'd0);

    // Engine works again after the reset.
    wf_delay = 1;
    applyStimulus(9'd1, 8'd2, 9'd2, 8'd2, 4'd1, 16'h4321);
    add_pix(1, 2); add_pix(2, 2);
    wait_idle("post");
    compare_caps("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
